// File: rtl/con_cm_pkg.sv
// Shared constants, response codes and FSM encoding for the CM console
// request scheduler.
package con_cm_pkg;

  localparam int ADDR_W     = 10;
  localparam int AREA1_LEN  = 64;
  localparam int AREA2_LEN  = 64;
  localparam int AREA3_LEN  = 384;
  localparam int AREA_TOTAL = AREA1_LEN + AREA2_LEN + AREA3_LEN;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_ERR     = 2'b01;
  localparam logic [1:0] RSP_TMO     = 2'b10;
  localparam logic [1:0] RSP_BADADDR = 2'b11;

  // One-hot scheduler states
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_CHECK = 6'b000010,
    ST_START = 6'b000100,
    ST_WAIT  = 6'b001000,
    ST_RESP  = 6'b010000,
    ST_GAP   = 6'b100000
  } state_t;

  // True when the base address falls outside the mapped console area
  function automatic logic addr_out_of_map(input logic [ADDR_W-1:0] addr,
                                           input int total);
    return (int'(addr) >= total);
  endfunction

endpackage

// File: rtl/con_req_fifo.sv
// Request queue: DEPTH x WIDTH, registered full/empty/ready flags and count.
// ready is a registered copy of !full, so a pop while full cannot admit a
// push in the same cycle.
module con_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [PW:0]      count_nxt;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and flags; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
      ready <= (count_nxt != CNT_FULL);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/con_req_sched_cm.sv
// CM console request scheduler: queues requests, rejects unmapped addresses,
// issues start pulses to the area controller, waits for done/error with a
// timeout, retries errors and returns one response per request.
//
//  state | meaning
//  IDLE  | waiting for a queued request; pops it and clears the retry count
//  CHECK | address range test; unmapped addresses skip straight to RESP
//  START | o_start_con high for this one cycle, timer cleared
//  WAIT  | waiting for done/error, bounded by the timer
//  RESP  | response registered out on the following cycle
//  GAP   | idle spacing after a response or before a retry start
module con_req_sched_cm
  import con_cm_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int AREA_TOTAL  = AREA1_LEN + AREA2_LEN + AREA3_LEN,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 1,
  parameter int GAP_CYC     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] im_req_addr,
  output logic              o_req_ready,
  output logic              o_start_con,
  output logic [ADDR_W-1:0] om_base_addr,
  input  logic              i_done_con,
  input  logic              i_error_con,
  output logic              o_rsp_valid,
  output logic [ADDR_W-1:0] om_rsp_addr,
  output logic [1:0]        om_rsp_code,
  output logic              o_busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [1:0]          rsp_code;
  logic [1:0]          retry_cnt;
  logic                retry_pend;
  logic [TW-1:0]       timer;
  logic [GW-1:0]       gap_cnt;

  logic                fifo_push;
  logic                fifo_pop;
  logic [ADDR_W-1:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign fifo_push = i_req_valid & o_req_ready;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;

  con_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (im_req_addr),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (o_req_ready),
    .count (fifo_count)
  );

  // Scheduler FSM with its timer, retry/gap counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      rsp_code     <= RSP_OK;
      retry_cnt    <= '0;
      retry_pend   <= 1'b0;
      timer        <= '0;
      gap_cnt      <= '0;
      o_start_con  <= 1'b0;
      om_base_addr <= '0;
      o_rsp_valid  <= 1'b0;
      om_rsp_addr  <= '0;
      om_rsp_code  <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_start_con <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_busy      <= (state != ST_IDLE) | ~fifo_empty;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_addr   <= fifo_rdata;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (addr_out_of_map(cur_addr, AREA_TOTAL)) begin
            rsp_code <= RSP_BADADDR;
            state    <= ST_RESP;
          end else begin
            o_start_con  <= 1'b1;
            om_base_addr <= cur_addr;
            state        <= ST_START;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done has priority over a coincident error
          if (i_done_con) begin
            rsp_code <= RSP_OK;
            state    <= ST_RESP;
          end else if (i_error_con) begin
            if (retry_cnt < RETRY_LIM) begin
              retry_cnt  <= retry_cnt + 1'b1;
              retry_pend <= 1'b1;
              gap_cnt    <= '0;
              state      <= ST_GAP;
            end else begin
              rsp_code <= RSP_ERR;
              state    <= ST_RESP;
            end
          end else if (timer == TMO_LAST) begin
            rsp_code <= RSP_TMO;
            state    <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          o_rsp_valid <= 1'b1;
          om_rsp_addr <= cur_addr;
          om_rsp_code <= rsp_code;
          retry_pend  <= 1'b0;
          gap_cnt     <= '0;
          state       <= ST_GAP;
        end
        ST_GAP: begin
          // spacing also covers the controller's completion cycle
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (retry_pend) begin
              retry_pend   <= 1'b0;
              o_start_con  <= 1'b1;
              om_base_addr <= cur_addr;
              state        <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_con_req_sched_cm.sv
// Scoreboard bench for con_req_sched_cm: the stimulus side predicts each
// request's outcome from its address and the planned controller replies,
// a responder plays the controller, and a monitor checks every start/response.
module tb_con_req_sched_cm;

  localparam int TMO   = 4096;
  localparam int MAXR  = 1;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_req_valid = 1'b0;
  logic [9:0] im_req_addr = '0;
  logic       o_req_ready;
  logic       o_start_con;
  logic [9:0] om_base_addr;
  logic       i_done_con = 1'b0;
  logic       i_error_con = 1'b0;
  logic       o_rsp_valid;
  logic [9:0] om_rsp_addr;
  logic [1:0] om_rsp_code;
  logic       o_busy;

  typedef struct { int kind; int dly; } act_t;
  typedef struct { logic [9:0] addr; bit retry; } st_t;
  typedef struct { logic [9:0] addr; logic [1:0] code; } rsp_t;

  act_t act_q[$];
  st_t  st_q[$];
  rsp_t rsp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_start = 0;
  int last_reply = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  con_req_sched_cm #(
    .FIFO_DEPTH  (DEPTH),
    .AREA_TOTAL  (512),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (MAXR),
    .GAP_CYC     (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .im_req_addr  (im_req_addr),
    .o_req_ready  (o_req_ready),
    .o_start_con  (o_start_con),
    .om_base_addr (om_base_addr),
    .i_done_con   (i_done_con),
    .i_error_con  (i_error_con),
    .o_rsp_valid  (o_rsp_valid),
    .om_rsp_addr  (om_rsp_addr),
    .om_rsp_code  (om_rsp_code),
    .o_busy       (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic act_t mk(input int kind, input int dly);
    act_t a;
    a.kind = kind;
    a.dly  = dly;
    return a;
  endfunction

  function automatic act_t rand_act();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60)      return mk(K_DONE, int'($urandom_range(0, 6)));
    else if (r < 85) return mk(K_ERR,  int'($urandom_range(0, 6)));
    else if (r < 95) return mk(K_BOTH, int'($urandom_range(0, 6)));
    else             return mk(K_NONE, 0);
  endfunction

  // Predict the outcome from the request rules, queue the expectations, then
  // present the request until the DUT accepts it.
  task automatic push(input logic [9:0] a, input act_t p0, input act_t p1);
    act_t pl[2];
    int   code;
    int   waited;
    rsp_t r;
    st_t  s;
    pl[0] = p0;
    pl[1] = p1;
    if (int'(a) >= 512) begin
      code = 3;
    end else begin
      code = -1;
      for (int k = 0; k <= MAXR && code < 0; k++) begin
        act_q.push_back(pl[k]);
        s.addr  = a;
        s.retry = (k > 0);
        st_q.push_back(s);
        if (pl[k].kind == K_DONE || pl[k].kind == K_BOTH) code = 0;
        else if (pl[k].kind == K_NONE)                     code = 2;
        else if (k == MAXR)                                code = 1;
      end
    end
    r.addr = a;
    r.code = 2'(code);
    rsp_q.push_back(r);
    @(negedge clk);
    i_req_valid = 1'b1;
    im_req_addr = a;
    waited = 0;
    while (!o_req_ready && waited < 40000) begin
      @(negedge clk);
      waited++;
    end
    if (!o_req_ready) begin
      check("push_accept_timeout", 32'(o_req_ready), 1);
      i_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while ((rsp_q.size() != 0 || o_busy) && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending_rsp", 32'(rsp_q.size()), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(output bit seen);
    int w;
    w = 0;
    seen = 1'b0;
    while (w < 100 && !seen) begin
      @(negedge clk);
      if (o_start_con) seen = 1'b1;
      w++;
    end
    if (!seen) check("start_wait_timeout", 0, 1);
  endtask

  // Monitor: every start and response is checked against the scoreboard
  initial begin
    st_t  s;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_start_con) begin
          if (st_q.size() == 0) begin
            check("unexpected_start", 32'(om_base_addr), 32'hFFFF);
          end else begin
            s = st_q.pop_front();
            check("start_addr", 32'(om_base_addr), 32'(s.addr));
            if (s.retry) check("retry_spacing_ok", 32'((cyc - last_start) >= GAP + 2), 1);
            last_start = cyc;
          end
        end
        if (o_rsp_valid) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", 32'({om_rsp_addr, om_rsp_code}), 32'hFFFF);
          end else begin
            r = rsp_q.pop_front();
            check("rsp_addr", 32'(om_rsp_addr), 32'(r.addr));
            check("rsp_code", 32'(om_rsp_code), 32'(r.code));
            // start cycle + TMO wait cycles + resp cycle, strobe next
            if (r.code == 2'b10) check("timeout_latency", 32'(cyc - last_start), 32'(TMO + 2));
            if (r.code == 2'b00 || r.code == 2'b01)
              check("reply_to_rsp_latency", 32'(cyc - last_reply), 2);
          end
        end
      end
    end
  end

  // Controller model: one planned reply per start
  initial begin
    act_t a;
    forever begin
      @(negedge clk);
      if (rst_n && o_start_con && act_q.size() > 0) begin
        a = act_q.pop_front();
        @(posedge clk);
        repeat (a.dly) @(posedge clk);
        #1;
        if (a.kind != K_NONE) begin
          i_done_con  = (a.kind == K_DONE || a.kind == K_BOTH);
          i_error_con = (a.kind == K_ERR  || a.kind == K_BOTH);
          last_reply  = cyc;
          @(posedge clk);
          #1;
          i_done_con  = 1'b0;
          i_error_con = 1'b0;
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    bit seen;
    logic [9:0] ra;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({o_req_ready, o_start_con, om_base_addr, o_rsp_valid,
                                om_rsp_addr, om_rsp_code, o_busy}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_reset", 32'(o_req_ready), 1);
    check("busy_after_reset", 32'(o_busy), 0);

    // basic ok request and start latency (accept edge -> start two edges later)
    push(10'h005, mk(K_DONE, 3), mk(K_DONE, 0));
    wait_start(seen);
    if (seen) check("start_latency", 32'(cyc - acc_cyc), 2);
    wait_idle(200);

    // unmapped address: no start, bad-address response
    push(10'h200, mk(K_DONE, 0), mk(K_DONE, 0));
    wait_idle(50);

    // error then done; two errors; done+error together
    push(10'h050, mk(K_ERR, 1), mk(K_DONE, 2));
    push(10'h1F0, mk(K_ERR, 0), mk(K_ERR, 3));
    push(10'h123, mk(K_BOTH, 2), mk(K_DONE, 0));
    wait_idle(500);

    // no reply: timeout
    push(10'h010, mk(K_NONE, 0), mk(K_DONE, 0));
    wait_idle(TMO + 100);

    // controller strobes while idle are ignored
    @(negedge clk);
    i_done_con = 1'b1;
    i_error_con = 1'b1;
    @(negedge clk);
    i_done_con = 1'b0;
    i_error_con = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_after_stray_strobe", 32'(o_busy), 0);

    // back-to-back: one in service plus DEPTH queued fills the queue
    for (int i = 0; i < DEPTH + 1; i++) push(10'(16 + i), mk(K_DONE, 4), mk(K_DONE, 0));
    @(negedge clk);
    check("ready_low_when_full", 32'(o_req_ready), 0);
    push(10'h1FF, mk(K_DONE, 1), mk(K_DONE, 0));
    wait_idle(2000);

    // reset while waiting on the controller drops the request
    push(10'h0AB, mk(K_NONE, 0), mk(K_DONE, 0));
    wait_start(seen);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("outputs_in_reset", 32'({o_req_ready, o_start_con, om_base_addr, o_rsp_valid,
                                   om_rsp_addr, om_rsp_code, o_busy}), 0);
    if (rsp_q.size() > 0) void'(rsp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_mid_reset", 32'(o_req_ready), 1);
    check("busy_after_mid_reset", 32'(o_busy), 0);
    push(10'h0CD, mk(K_DONE, 2), mk(K_DONE, 0));
    wait_idle(200);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) ra = 10'($urandom_range(512, 1023));
      else                           ra = 10'($urandom_range(0, 511));
      push(ra, rand_act(), rand_act());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(60000);
    check("starts_all_seen", 32'(st_q.size()), 0);
    check("replies_all_used", 32'(act_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
